// File: rtl/acs_pm_array.sv
// Add-compare-select stage with path-metric register bank for an 8-state
// rate-1/2 Viterbi decoder. Each valid symbol updates every path metric and
// produces one survivor decision bit per state, the best state and a
// normalisation flag. Single-cycle latency, full-rate throughput.
module acs_pm_array #(
  parameter  int NUM_STATES = 8,
  parameter  int BM_W       = 2,
  parameter  int PM_W       = 8,
  parameter  int INIT_PM    = 16,
  localparam int ST_W       = $clog2(NUM_STATES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [NUM_STATES*BM_W-1:0] bm0_bus,
  input  logic [NUM_STATES*BM_W-1:0] bm1_bus,
  output logic [NUM_STATES-1:0]      dec_out,
  output logic                       dec_valid,
  output logic [ST_W-1:0]            best_state,
  output logic                       norm_pulse,
  output logic [NUM_STATES*PM_W-1:0] pm_bus
);

  // Frame-start metric: state 0 is the known starting state, all others
  // begin with a penalty so the trellis converges from state 0.
  function automatic logic [PM_W-1:0] rst_pm(input int s);
    return (s == 0) ? '0 : PM_W'(INIT_PM);
  endfunction

  logic [PM_W-1:0]       pm_reg  [NUM_STATES];
  logic [PM_W-1:0]       old_pm  [NUM_STATES];
  logic [PM_W-1:0]       acs_pm  [NUM_STATES];
  logic [PM_W-1:0]       pm_next [NUM_STATES];
  logic [NUM_STATES-1:0] dec_next;
  logic [NUM_STATES-1:0] msb_vec;
  logic                  norm_next;
  logic [ST_W-1:0]       best_next;
  logic [PM_W-1:0]       best_pm;

  logic [NUM_STATES-1:0] dec_reg;
  logic                  dec_valid_reg;
  logic [ST_W-1:0]       best_reg;
  logic                  norm_reg;

  // Metrics only carry the MSB when every state has crossed the halfway
  // point, so clearing it preserves all metric differences.
  assign norm_next = &msb_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STATES; gi++) begin : g_acs
      localparam int P0 = (2 * gi) % NUM_STATES;
      localparam int P1 = P0 + 1;
      logic [PM_W:0] c0;
      logic [PM_W:0] c1;
      logic [PM_W:0] cmin;

      // start forces the reset metrics as the predecessors of this symbol
      assign old_pm[gi] = start ? rst_pm(gi) : pm_reg[gi];

      assign c0 = {1'b0, old_pm[P0]} + (PM_W+1)'(bm0_bus[gi*BM_W +: BM_W]);
      assign c1 = {1'b0, old_pm[P1]} + (PM_W+1)'(bm1_bus[gi*BM_W +: BM_W]);

      // Ties resolve to the even predecessor
      assign dec_next[gi] = (c1 < c0);
      assign cmin         = dec_next[gi] ? c1 : c0;
      assign acs_pm[gi]   = cmin[PM_W] ? '1 : cmin[PM_W-1:0];
      assign msb_vec[gi]  = acs_pm[gi][PM_W-1];
      assign pm_next[gi]  = norm_next ? {1'b0, acs_pm[gi][PM_W-2:0]} : acs_pm[gi];

      assign pm_bus[gi*PM_W +: PM_W] = pm_reg[gi];
    end
  endgenerate

  // Minimum search over pre-normalisation metrics; strict compare keeps the
  // lowest index on ties.
  always_comb begin
    best_next = '0;
    best_pm   = acs_pm[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (acs_pm[i] < best_pm) begin
        best_pm   = acs_pm[i];
        best_next = ST_W'(i);
      end
    end
  end

  // Path-metric bank: load ACS result per symbol, reload on frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STATES; i++) pm_reg[i] <= rst_pm(i);
    end else if (in_valid) begin
      for (int i = 0; i < NUM_STATES; i++) pm_reg[i] <= pm_next[i];
    end else if (start) begin
      for (int i = 0; i < NUM_STATES; i++) pm_reg[i] <= rst_pm(i);
    end
  end

  // Decision/status outputs: captured per symbol, strobes last one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_reg       <= '0;
      dec_valid_reg <= 1'b0;
      best_reg      <= '0;
      norm_reg      <= 1'b0;
    end else if (in_valid) begin
      dec_reg       <= dec_next;
      dec_valid_reg <= 1'b1;
      best_reg      <= best_next;
      norm_reg      <= norm_next;
    end else begin
      dec_valid_reg <= 1'b0;
      norm_reg      <= 1'b0;
    end
  end

  assign dec_out    = dec_reg;
  assign dec_valid  = dec_valid_reg;
  assign best_state = best_reg;
  assign norm_pulse = norm_reg;

endmodule

// File: tb/tb_acs_pm_array.sv
// Self-checking bench for acs_pm_array: directed trellis cases plus random
// symbols checked against an integer-arithmetic Viterbi ACS model.
module tb_acs_pm_array;
  localparam int NS  = 8;
  localparam int BW  = 2;
  localparam int PW  = 8;
  localparam int IPM = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [NS*BW-1:0]  bm0_bus;
  logic [NS*BW-1:0]  bm1_bus;
  logic [NS-1:0]     dec_out;
  logic              dec_valid;
  logic [2:0]        best_state;
  logic              norm_pulse;
  logic [NS*PW-1:0]  pm_bus;

  acs_pm_array #(.NUM_STATES(NS), .BM_W(BW), .PM_W(PW), .INIT_PM(IPM)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .bm0_bus(bm0_bus), .bm1_bus(bm1_bus), .dec_out(dec_out),
    .dec_valid(dec_valid), .best_state(best_state), .norm_pulse(norm_pulse),
    .pm_bus(pm_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int txn   = 0;
  int dv_count;

  // reference model state
  int       mpm [NS];
  bit [7:0] mdec;
  int       mbest;
  bit       mnorm;
  bit       mdv;
  int       cur_b0 [NS];
  int       cur_b1 [NS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_pm_bus();
    logic [63:0] r;
    r = '0;
    for (int s = 0; s < NS; s++) r[s*PW +: PW] = mpm[s][PW-1:0];
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) mpm[s] = (s == 0) ? 0 : IPM;
    mdec = '0; mbest = 0; mnorm = 0; mdv = 0;
  endtask

  // Viterbi ACS from first principles on plain integers
  task automatic model_update(input bit st, input bit v);
    int old [NS];
    int nw  [NS];
    bool_all: begin end
    if (v) begin
      bit all_hi;
      for (int s = 0; s < NS; s++) old[s] = st ? ((s == 0) ? 0 : IPM) : mpm[s];
      all_hi = 1;
      mbest  = 0;
      for (int s = 0; s < NS; s++) begin
        int c0, c1, p;
        p  = (2 * s) % NS;
        c0 = old[p] + cur_b0[s];
        c1 = old[p+1] + cur_b1[s];
        mdec[s] = (c1 < c0);
        nw[s]   = (c1 < c0) ? c1 : c0;
        if (nw[s] > 255) nw[s] = 255;
        if (nw[s] < 128) all_hi = 0;
      end
      for (int s = 1; s < NS; s++) if (nw[s] < nw[mbest]) mbest = s;
      for (int s = 0; s < NS; s++) mpm[s] = all_hi ? nw[s] - 128 : nw[s];
      mnorm = all_hi;
      mdv   = 1;
    end else begin
      mdv   = 0;
      mnorm = 0;
      if (st) for (int s = 0; s < NS; s++) mpm[s] = (s == 0) ? 0 : IPM;
    end
  endtask

  task automatic set_bm(input int b0, input int b1);
    for (int s = 0; s < NS; s++) begin cur_b0[s] = b0; cur_b1[s] = b1; end
  endtask

  // one clock cycle of stimulus, followed by a full output comparison
  task automatic step(input bit st, input bit v);
    @(negedge clk);
    start    = st;
    in_valid = v;
    for (int s = 0; s < NS; s++) begin
      bm0_bus[s*BW +: BW] = cur_b0[s][BW-1:0];
      bm1_bus[s*BW +: BW] = cur_b1[s][BW-1:0];
    end
    model_update(st, v);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    txn++;
    if (dec_valid) dv_count++;
    $display("txn %0d start=%0b valid=%0b dec_valid=%0b dec=%02h best=%0d norm=%0b pm=%016h",
             txn, st, v, dec_valid, dec_out, best_state, norm_pulse, pm_bus);
    check("pm_bus", pm_bus, model_pm_bus());
    check("dec_valid", dec_valid, mdv);
    check("norm_pulse", norm_pulse, mnorm);
    check("dec_out", dec_out, mdec);
    check("best_state", best_state, mbest);
  endtask

  // asynchronous reset: outputs must clear with no clock edge in between
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    model_reset();
    check("rst_pm_bus", pm_bus, 64'h1010101010101000);
    check("rst_dec_valid", dec_valid, 1'b0);
    check("rst_dec_out", dec_out, 8'h00);
    check("rst_best", best_state, 3'd0);
    check("rst_norm", norm_pulse, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; bm0_bus = '0; bm1_bus = '0;
    dv_count = 0;
    #2;
    do_reset();

    // bm0=0, bm1=2: even predecessors win everywhere
    set_bm(0, 2);
    step(0, 1);
    check("t1_pm", pm_bus, 64'h1010100010101000);
    check("t1_dec", dec_out, 8'h00);

    // bm0=2, bm1=0: odd predecessor better except into states 0 and 4
    do_reset();
    set_bm(2, 0);
    step(0, 1);
    check("t2_pm", pm_bus, 64'h1010100210101002);
    check("t2_dec", dec_out, 8'hEE);
    check("t2_best", best_state, 3'd0);

    // all-zero metrics: 16 vs 16 ties pick p0
    do_reset();
    set_bm(0, 0);
    step(0, 1);
    check("t3_dec", dec_out, 8'h00);

    // 64 symbols of bm=2 drive all metrics to 128 -> normalise to 0
    do_reset();
    set_bm(2, 2);
    for (int k = 1; k <= 64; k++) begin
      step(0, 1);
      if (k == 10) check("t4_pm_k10", pm_bus, {8{8'd20}});
      if (k == 63) check("t4_norm_k63", norm_pulse, 1'b0);
    end
    check("t4_pm_norm", pm_bus, 64'h0);
    check("t4_norm", norm_pulse, 1'b1);
    check("t4_best", best_state, 3'd0);
    set_bm(0, 0);
    step(0, 0);
    check("t4_norm_clr", norm_pulse, 1'b0);

    // start with in_valid mid-frame (all pm 40) matches first-symbol case
    do_reset();
    set_bm(2, 2);
    for (int k = 0; k < 20; k++) step(0, 1);
    check("t5_pm40", pm_bus, {8{8'd40}});
    set_bm(2, 0);
    step(1, 1);
    check("t5_pm", pm_bus, 64'h1010100210101002);
    check("t5_dec", dec_out, 8'hEE);

    // start alone reloads metrics without a decision strobe
    set_bm(1, 3);
    step(0, 1);
    step(1, 0);
    check("t6_pm", pm_bus, 64'h1010101010101000);
    check("t6_dv", dec_valid, 1'b0);

    // reset while a decision strobe is high
    set_bm(3, 1);
    step(0, 1);
    do_reset();

    // gapped input: two strobes, metrics held through the gap
    dv_count = 0;
    set_bm(1, 2);
    step(0, 1);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    step(0, 0);
    check("t7_pulses", dv_count, 2);

    // random symbols, gaps, starts and occasional resets
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < NS; s++) begin
        cur_b0[s] = $urandom_range(0, 3);
        cur_b1[s] = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acs_pm_array.md
Name: acs_pm_array

Overview:
Add-compare-select stage and path-metric register bank for the hard-decision, rate-1/2, K=4 (8-state) Viterbi decoder. It sits directly downstream of the per-state branch-metric units and consumes their two 2-bit branch metrics per state. Each valid symbol, it updates all path metrics and emits one survivor decision bit per state. The decision bits feed the traceback unit.

Parameters:
NUM_STATES, 8, number of trellis states; power of 2; ST_W = log2(NUM_STATES).
BM_W, 2, branch metric width, as produced by the branch-metric units.
PM_W, 8, path metric register width.
INIT_PM, 16, initial metric for every state except state 0 at reset/start; must be < 2^(PM_W-1).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  reinitialise path metrics (frame start).
in_valid  in  1  branch metrics valid this cycle; one symbol per asserted cycle.
bm0_bus  in  NUM_STATES*BM_W  slice s = metric of branch into state s from predecessor p0(s).
bm1_bus  in  NUM_STATES*BM_W  slice s = metric of branch into state s from predecessor p1(s).
dec_out  out  NUM_STATES  survivor decision per state; 1 = p1 chosen.
dec_valid  out  1  dec_out/best_state valid strobe.
best_state  out  ST_W  state with the minimum updated metric.
norm_pulse  out  1  normalisation applied on this update.
pm_bus  out  NUM_STATES*PM_W  current path metric registers, slice s = pm[s].

Behaviour:
- Trellis: p0(s) = (2*s) mod NUM_STATES, p1(s) = p0(s)+1.
- Reset (async, rst=1): pm[0]=0, pm[s≠0]=INIT_PM; dec_out=0, dec_valid=0, best_state=0, norm_pulse=0. Reset mid-frame discards all state immediately; the first in_valid after release uses the reset metrics.
- Per in_valid cycle, for every s: c0 = pm[p0]+bm0[s], c1 = pm[p1]+bm1[s], computed PM_W+1 wide. new[s] = min(c0,c1). dec[s] = 1 only if c1 < c0 strictly; tie -> 0. Saturate new[s] at 2^PM_W-1 if bit PM_W is set.
- Normalisation: if every new[s] has bit PM_W-1 set, clear that bit in all metrics before storing; norm_pulse=1 for that update, else 0.
- best_state: index of the minimum new[s] (pre-normalisation). Lowest index wins ties.
- Latency: 1 cycle. Registers pm, dec_out, best_state, norm_pulse update on the clock edge sampling in_valid=1. dec_valid=1 for exactly the following cycle, then returns to 0.
- in_valid=0: pm, dec_out, best_state hold; dec_valid=0, norm_pulse=0.
- No backpressure. The consumer must accept every dec_valid cycle. Back-to-back in_valid is supported at full rate.
- start without in_valid: pm reloads to reset values on the next edge; dec_valid=0.
- start with in_valid: the ACS for that symbol uses the reset values (0 / INIT_PM) as old metrics, not the current registers. Outputs reflect that update normally.
- rst has priority over everything.

Test Plan:
- Reset, then in_valid with all bm0=0, bm1=2 -> next cycle dec_valid=1, dec_out=0x00, pm0=pm4=0, all other pm=16, best_state=0, norm_pulse=0.
- After reset, one symbol with all bm0=2, bm1=0 -> pm0=2 (2 vs 16, dec0=0), pm4=2 (dec4=0), pm1=16 (18 vs 16, dec1=1), and likewise dec[s]=1 for s∈{1,2,3,5,6,7}; dec_out=0xEE, best_state=0.
- Tie: reset, all bm=0 -> pm1 candidates 16 vs 16 -> dec1=0; dec_out=0x00.
- Normalisation: reset, 64 consecutive symbols with all bm0=bm1=2 -> after symbol k≥3 all pm=2k. The 64th update gives all pm=0, norm_pulse=1 on that dec_valid only, best_state=0.
- start asserted together with in_valid mid-frame (pm all 40) -> result identical to the first-symbol-after-reset case. rst pulse mid-stream -> pm_bus immediately returns to 0/16×7 and dec_valid=0 without a clock edge.
- Gapped input (in_valid 1,0,0,1) -> exactly two dec_valid pulses, each one cycle after its in_valid; pm_bus holds during the gap.
